// File: rtl/axis_frame_player_if.sv
// AXI-Stream data channel carrying one complex sample per beat, packed as {im, re}.
// Handshake: a beat transfers on a rising edge where tvalid && tready are both high;
// once tvalid is raised, tdata and tlast hold until that transfer, and tvalid never
// depends combinationally on tready.
interface axis_frame_player_if #(
  parameter int DATA_WID = 16
) ();
  logic [2*DATA_WID-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_player.sv
// Frame player: replays a RAM of complex samples on an AXI-Stream master, with tlast
// on the last beat of every FFT_LEN frame. A pass covers the whole RAM; with loop set,
// passes repeat back to back. Reads run one cycle ahead into a 2-entry skid so the
// stream has no bubbles, and any beats fetched past the end of a non-looping pass are
// discarded when the final beat is accepted.
module axis_frame_player #(
  parameter int DATA_WID = 16,
  parameter int FFT_LEN  = 64,
  parameter int NFRAMES  = 4,
  localparam int SAMP    = FFT_LEN * NFRAMES,
  localparam int AW      = $clog2(SAMP)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [2*DATA_WID-1:0] wr_data,
  input  logic                  start,
  input  logic                  loop,
  axis_frame_player_if.master   m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frames_sent,
  output logic                  wr_err,
  output logic [1:0]            fsm_state
);

  localparam int DW = 2 * DATA_WID;
  localparam int LW = $clog2(FFT_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] ram [SAMP];
  logic [DW-1:0] ram_q;
  logic          ram_q_vld;
  logic          ram_q_last;
  logic          ram_q_end;
  logic [AW-1:0] rd_ptr;
  // skid entry layout: {pass_end, tlast, data}
  logic [DW+1:0] skid [2];
  logic          wr_idx;
  logic          rd_idx;
  logic [1:0]    count;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;
  logic          flush;
  logic          wr_ok;
  logic          head_end;

  assign pop      = (count != 2'd0) && m_axis.tready;
  assign occ      = count + {1'b0, ram_q_vld};
  assign head_end = skid[rd_idx][DW+1];
  assign wr_ok    = wr_en && ((state == IDLE) || (state == DONE));

  assign m_axis.tvalid = (count != 2'd0);
  assign m_axis.tdata  = skid[rd_idx][DW-1:0];
  assign m_axis.tlast  = skid[rd_idx][DW];
  assign busy          = (state == PRIME) || (state == STREAM);
  assign fsm_state     = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, read issue (keeps skid + read stage at most two deep) and end-of-pass flush.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = PRIME;
      end
      PRIME: begin
        issue     = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (pop && head_end && !loop) begin
          flush     = 1'b1;
          state_nxt = DONE;
        end else begin
          issue = (occ < 2'd2) || (pop && (occ == 2'd2));
        end
      end
      DONE: begin
        if (start) state_nxt = PRIME;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sample RAM: loaded only while idle, synchronous one-cycle read; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) ram[wr_addr] <= wr_data;
    if (issue) ram_q <= ram[rd_ptr];
  end

  // Read pointer, skid buffer, status flags and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q_vld   <= 1'b0;
      ram_q_last  <= 1'b0;
      ram_q_end   <= 1'b0;
      rd_ptr      <= '0;
      skid[0]     <= '0;
      skid[1]     <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      count       <= 2'd0;
      done        <= 1'b0;
      frames_sent <= 16'd0;
      wr_err      <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (pop && m_axis.tlast) frames_sent <= frames_sent + 16'd1;
      if (flush)                       done <= 1'b1;
      else if (state == DONE && start) done <= 1'b0;
      if (flush) begin
        // Drop any beats prefetched from the next pass and rewind for the next start.
        ram_q_vld <= 1'b0;
        rd_ptr    <= '0;
        wr_idx    <= 1'b0;
        rd_idx    <= 1'b0;
        count     <= 2'd0;
      end else begin
        if (ram_q_vld) begin
          skid[wr_idx] <= {ram_q_end, ram_q_last, ram_q};
          wr_idx       <= ~wr_idx;
        end
        if (pop) rd_idx <= ~rd_idx;
        count     <= count + {1'b0, ram_q_vld} - {1'b0, pop};
        ram_q_vld <= issue;
        if (issue) begin
          ram_q_last <= &rd_ptr[LW-1:0];
          ram_q_end  <= (rd_ptr == AW'(SAMP - 1));
          rd_ptr     <= (rd_ptr == AW'(SAMP - 1)) ? '0 : rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_player.sv
// Bench for axis_frame_player: reference stream built from a model RAM and the
// frame/tlast rules, compared beat by beat, plus table and hand-written corner cases.
module tb_axis_frame_player;
  localparam int DW   = 16;
  localparam int FL   = 64;
  localparam int NF   = 4;
  localparam int SAMP = FL * NF;
  localparam int AW   = $clog2(SAMP);
  localparam int W    = 2 * DW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [2*DW-1:0] wr_data = '0;
  logic            start = 1'b0;
  logic            loop = 1'b0;
  logic            busy, done, wr_err;
  logic [15:0]     frames_sent;
  logic [1:0]      fsm_state;

  axis_frame_player_if #(.DATA_WID(DW)) ax ();

  axis_frame_player #(.DATA_WID(DW), .FFT_LEN(FL), .NFRAMES(NF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .loop        (loop),
    .m_axis      (ax),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent),
    .wr_err      (wr_err),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int              errors = 0;
  int              checks = 0;
  logic [W-1:0]    exp_q[$];
  logic [2*DW-1:0] model_ram [SAMP];
  logic [2*DW-1:0] cap_data [SAMP];
  logic            cap_last [SAMP];
  bit              mon_on = 1'b0;
  bit              rand_ready = 1'b0;
  bit              ready_lvl = 1'b0;
  int              hs_n = 0;
  int              first_cyc = 0;
  int              last_cyc = 0;
  int              cyc = 0;
  bit              prev_stall = 1'b0;
  logic [2*DW-1:0] prev_data;
  logic            prev_last;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] data;
    logic            exp_last;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // tready: either a fixed level or a 50% random pattern, changed just after each edge.
  always @(posedge clk) begin
    #1;
    ax.tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  // Monitor: on the falling edge, check AXIS hold rules and score accepted beats.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && mon_on) begin
      if (prev_stall) begin
        check("hold_valid", 64'(ax.tvalid), 64'(1'b1));
        check("hold_data", 64'(ax.tdata), 64'(prev_data));
        check("hold_last", 64'(ax.tlast), 64'(prev_last));
      end
      if (ax.tvalid && ax.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got beat %0h with no beat expected (t=%0t)", ax.tdata, $time);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", 64'(ax.tdata), 64'(e[2*DW-1:0]));
          check("beat_last", 64'(ax.tlast), 64'(e[2*DW]));
        end
        cap_data[hs_n % SAMP] = ax.tdata;
        cap_last[hs_n % SAMP] = ax.tlast;
        if (hs_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        hs_n++;
      end
      prev_stall = ax.tvalid && !ax.tready;
      prev_data  = ax.tdata;
      prev_last  = ax.tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- reference model and driver tasks ----------------
  // One pass: beat k carries ram[k]; tlast on the last sample of every frame.
  task automatic push_pass();
    for (int k = 0; k < SAMP; k++)
      exp_q.push_back({((k % FL) == FL - 1) ? 1'b1 : 1'b0, model_ram[k]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_n = 0;
    first_cyc = 0;
    last_cyc = 0;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    start = 1'b0;
    loop = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [2*DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int t = 0;
    while (hs_n < n && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (hs_n < n) begin
      errors++;
      $display("FAIL %s: timeout, beats=%0d required=%0d", name, hs_n, n);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, beats outstanding=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 64'(ax.tvalid), 64'(0));
    check({tag, "_tlast"}, 64'(ax.tlast), 64'(0));
    check({tag, "_tdata"}, 64'(ax.tdata), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_frames"}, 64'(frames_sent), 64'(0));
    check({tag, "_wr_err"}, 64'(wr_err), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [2*DW-1:0] d;

    tbl[0]  = '{8'd0,   32'hA5A5_0000, 1'b0};
    tbl[1]  = '{8'd1,   32'h1234_5678, 1'b0};
    tbl[2]  = '{8'd62,  32'hFFFF_0001, 1'b0};
    tbl[3]  = '{8'd63,  32'h0BAD_F00D, 1'b1};
    tbl[4]  = '{8'd64,  32'hDEAD_BEEF, 1'b0};
    tbl[5]  = '{8'd127, 32'h7FFF_8000, 1'b1};
    tbl[6]  = '{8'd128, 32'h8000_7FFF, 1'b0};
    tbl[7]  = '{8'd191, 32'hC0DE_1234, 1'b1};
    tbl[8]  = '{8'd192, 32'h0000_FFFF, 1'b0};
    tbl[9]  = '{8'd254, 32'h5555_AAAA, 1'b0};
    tbl[10] = '{8'd255, 32'hFFFF_FFFF, 1'b1};

    // Reset values.
    tick();
    check_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    mon_on = 1'b1;
    check_reset_outputs("rst_rel");

    // Test 1: ramp, tready=1, latency and no bubbles.
    for (int k = 0; k < SAMP; k++) begin
      write_word(AW'(k), 32'(k));
      model_ram[k] = 32'(k);
    end
    ready_lvl = 1'b1;
    clear_mon();
    push_pass();
    pulse_start();
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_lat0_tvalid", 64'(ax.tvalid), 64'(0));
    tick();
    check("t1_lat1_tvalid", 64'(ax.tvalid), 64'(0));
    tick();
    check("t1_lat2_tvalid", 64'(ax.tvalid), 64'(1));
    check("t1_lat2_tdata", 64'(ax.tdata), 64'(model_ram[0]));
    wait_drain(400, "t1_drain");
    check("t1_beats", 64'(hs_n), 64'(SAMP));
    check("t1_span", 64'(last_cyc - first_cyc), 64'(SAMP - 1));
    check("t1_done", 64'(done), 64'(1));
    check("t1_busy_end", 64'(busy), 64'(0));
    check("t1_tvalid_end", 64'(ax.tvalid), 64'(0));
    check("t1_frames", 64'(frames_sent), 64'(4));

    // Test 2: table of boundary writes (in DONE), random tready.
    for (int i = 0; i < 11; i++) begin
      write_word(tbl[i].addr, tbl[i].data);
      model_ram[tbl[i].addr] = tbl[i].data;
    end
    rand_ready = 1'b1;
    clear_mon();
    push_pass();
    pulse_start();
    check("t2_done_cleared", 64'(done), 64'(0));
    wait_drain(3000, "t2_drain");
    for (int i = 0; i < 11; i++) begin
      check("t2_tbl_data", 64'(cap_data[tbl[i].addr]), 64'(tbl[i].data));
      check("t2_tbl_last", 64'(cap_last[tbl[i].addr]), 64'(tbl[i].exp_last));
    end
    check("t2_beats", 64'(hs_n), 64'(SAMP));
    check("t2_frames", 64'(frames_sent), 64'(8));

    // Random RAM contents, random tready.
    for (int k = 0; k < SAMP; k++) begin
      d = $urandom;
      write_word(AW'(k), d);
      model_ram[k] = d;
    end
    clear_mon();
    push_pass();
    pulse_start();
    wait_drain(3000, "t2r_drain");
    check("t2r_frames", 64'(frames_sent), 64'(12));
    check("t2r_done", 64'(done), 64'(1));

    // Test 3: loop for 600 beats then drop loop; ends at beat 767, no bubbles.
    do_reset();
    rand_ready = 1'b0;
    ready_lvl = 1'b1;
    loop = 1'b1;
    clear_mon();
    push_pass();
    push_pass();
    push_pass();
    pulse_start();
    wait_beats(600, 1000, "t3_wait600");
    check("t3_done_mid", 64'(done), 64'(0));
    loop = 1'b0;
    wait_drain(500, "t3_drain");
    repeat (4) tick();
    check("t3_beats", 64'(hs_n), 64'(3 * SAMP));
    check("t3_span", 64'(last_cyc - first_cyc), 64'(3 * SAMP - 1));
    check("t3_frames", 64'(frames_sent), 64'(12));
    check("t3_done", 64'(done), 64'(1));
    check("t3_tvalid_end", 64'(ax.tvalid), 64'(0));

    // Test 4: write and start during STREAM are dropped/ignored.
    clear_mon();
    push_pass();
    pulse_start();
    wait_beats(50, 200, "t4_wait50");
    check("t4_busy", 64'(busy), 64'(1));
    check("t4_wr_err_pre", 64'(wr_err), 64'(0));
    wr_en = 1'b1;
    wr_addr = AW'(5);
    wr_data = ~model_ram[5];
    tick();
    wr_en = 1'b0;
    check("t4_wr_err_pulse", 64'(wr_err), 64'(1));
    tick();
    check("t4_wr_err_clear", 64'(wr_err), 64'(0));
    pulse_start();
    wait_drain(500, "t4_drain");
    check("t4_beats", 64'(hs_n), 64'(SAMP));
    check("t4_frames", 64'(frames_sent), 64'(16));
    rand_ready = 1'b1;
    clear_mon();
    push_pass();
    pulse_start();
    wait_drain(3000, "t4b_drain");
    check("t4b_ram5", 64'(cap_data[5]), 64'(model_ram[5]));
    check("t4b_frames", 64'(frames_sent), 64'(20));

    // Test 5: reset mid-pass, RAM retained.
    rand_ready = 1'b0;
    ready_lvl = 1'b1;
    clear_mon();
    push_pass();
    pulse_start();
    wait_beats(100, 300, "t5_wait100");
    check("t5_tvalid_pre", 64'(ax.tvalid), 64'(1));
    #3;
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    mon_on = 1'b1;
    clear_mon();
    push_pass();
    pulse_start();
    wait_drain(500, "t5_drain");
    check("t5_ram0", 64'(cap_data[0]), 64'(model_ram[0]));
    check("t5_frames", 64'(frames_sent), 64'(4));

    // Test 6: write to address 0 and start in the same IDLE cycle.
    do_reset();
    d = ~model_ram[0];
    model_ram[0] = d;
    clear_mon();
    push_pass();
    wr_en = 1'b1;
    wr_addr = '0;
    wr_data = d;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    wait_drain(500, "t6_drain");
    check("t6_beat0", 64'(cap_data[0]), 64'(d));
    check("t6_frames", 64'(frames_sent), 64'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
